// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, the instruction memory and the decode stage.
// The queue itself uses the master view; memory/decode/execute models use the slave view.
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_rvalid;
  logic [DATA_W-1:0] im_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output im_req, im_addr, out_valid, out_pc, out_inst, count,
    input  im_rvalid, im_rdata, redirect, redirect_addr, out_ready
  );

  modport slave (
    input  im_req, im_addr, out_valid, out_pc, out_inst, count,
    output im_rvalid, im_rdata, redirect, redirect_addr, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential one-cycle-latency fetches and buffers
// returned instructions with their PCs; a redirect flushes queued and in-flight work.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [CNT_W:0]    credit_used;
  logic              head_valid;
  logic              push;
  logic              pop;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    credit_used = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    issue       = 1'b0;
    issue_addr  = fetch_pc_q;
    if (rst) begin
      issue = 1'b0;
    end else if (fq.redirect) begin
      issue      = 1'b1;
      issue_addr = fq.redirect_addr;
    end else begin
      // Credit ignores a same-cycle pop, so a push can never land on a full queue.
      issue = credit_used < (CNT_W+1)'(DEPTH);
    end

    push       = !rst && !fq.redirect && fq.im_rvalid && inflight_q;
    head_valid = !rst && !fq.redirect && (count_q != '0);
    pop        = head_valid && fq.out_ready;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign fq.im_req    = issue;
  assign fq.im_addr   = issue_addr;
  assign fq.out_valid = head_valid;
  assign fq.out_pc    = rst ? '0 : pc_mem_q[rd_ptr_q];
  assign fq.out_inst  = rst ? '0 : inst_mem_q[rd_ptr_q];
  assign fq.count     = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      // NOTE: the storage is cleared on reset too, so the head shows zeros rather
      // than stale instructions; this costs a reset net on every storage flop.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        req_pc_q   <= issue_addr;
        fetch_pc_q <= issue_addr + ADDR_W'(4);
      end

      if (fq.redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= req_pc_q;
          inst_mem_q[wr_ptr_q] <= fq.im_rdata;
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_d;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) fq ();

  fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return a ^ 32'h5A3C_9E17;
  endfunction

  // Reference model: a plain queue of {pc, inst} plus the fetch cursor.
  entry_t            mq[$];
  logic [ADDR_W-1:0] m_fetch;
  logic [ADDR_W-1:0] m_req_pc;
  bit                m_inflight;
  bit                synced;
  bit                seen_dead;
  bit                resp_v;
  logic [DATA_W-1:0] resp_d;
  bit                e_req;
  logic [ADDR_W-1:0] e_addr;
  bit                e_valid;
  bit                m_push;
  bit                m_pop;

  initial begin
    synced     = 1'b0;
    seen_dead  = 1'b0;
    resp_v     = 1'b0;
    resp_d     = '0;
    m_inflight = 1'b0;
    m_fetch    = '0;
    m_req_pc   = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      e_req   = 1'b0;
      e_valid = 1'b0;
    end else begin
      e_req   = fq.redirect ? 1'b1 : ((mq.size() + int'(m_inflight)) < DEPTH);
      e_valid = !fq.redirect && (mq.size() != 0);
    end
    e_addr = fq.redirect ? fq.redirect_addr : m_fetch;

    if (synced) begin
      check("im_req", fq.im_req, e_req);
      if (e_req) check("im_addr", fq.im_addr, e_addr);
      check("out_valid", fq.out_valid, e_valid);
      if (e_valid) begin
        check("out_pc", fq.out_pc, mq[0].pc);
        check("out_inst", fq.out_inst, mq[0].inst);
      end
      if (rst) begin
        check("rst_out_pc", fq.out_pc, 0);
        check("rst_out_inst", fq.out_inst, 0);
      end
      check("count", fq.count, mq.size());
    end
    if (fq.out_valid === 1'b1 && fq.out_inst === 32'hDEADBEEF) seen_dead = 1'b1;

    // Memory responder: answer the request seen this cycle in the next one.
    resp_v = (fq.im_req === 1'b1);
    resp_d = mem_data(fq.im_addr);

    if (rst) begin
      mq.delete();
      m_fetch    = '0;
      m_inflight = 1'b0;
      synced     = 1'b1;
    end else begin
      m_push = fq.im_rvalid && m_inflight && !fq.redirect;
      m_pop  = e_valid && fq.out_ready;
      if (fq.redirect) begin
        mq.delete();
      end else begin
        if (m_push && synced) check("no_push_when_full", mq.size() < DEPTH, 1);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back('{pc: m_req_pc, inst: fq.im_rdata});
      end
      if (e_req) begin
        m_req_pc = e_addr;
        m_fetch  = e_addr + 32'd4;
      end
      m_inflight = e_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    fq.im_rvalid = resp_v;
    fq.im_rdata  = resp_d;
  endtask

  task automatic cyc(input bit r, input bit rd, input logic [ADDR_W-1:0] ra, input bit rdy);
    tick();
    rst              = r;
    fq.redirect      = rd;
    fq.redirect_addr = ra;
    fq.out_ready     = rdy;
    #1;
  endtask

  logic [19:0] pat;

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b1;
    fq.redirect      = 1'b0;
    fq.redirect_addr = '0;
    fq.out_ready     = 1'b1;
    fq.im_rvalid     = 1'b0;
    fq.im_rdata      = '0;

    // Reset, then streaming with out_ready = 1.
    repeat (3) cyc(1, 0, 0, 1);
    check("rst_im_req", fq.im_req, 0);
    check("rst_valid", fq.out_valid, 0);
    check("rst_count", fq.count, 0);
    check("rst_pc", fq.out_pc, 0);
    cyc(0, 0, 0, 1);
    check("t0_req", fq.im_req, 1);
    check("t0_addr", fq.im_addr, 32'h0);
    cyc(0, 0, 0, 1);
    check("t1_addr", fq.im_addr, 32'h4);
    check("t1_valid", fq.out_valid, 0);
    cyc(0, 0, 0, 1);
    check("t2_addr", fq.im_addr, 32'h8);
    check("t2_valid", fq.out_valid, 1);
    check("t2_pc", fq.out_pc, 32'h0);
    check("t2_inst", fq.out_inst, mem_data(32'h0));
    check("t2_count", fq.count, 1);
    cyc(0, 0, 0, 1);
    check("t3_pc", fq.out_pc, 32'h4);
    check("t3_count", fq.count, 1);
    cyc(0, 0, 0, 1);
    check("t4_pc", fq.out_pc, 32'h8);

    // Stalled from reset: queue fills to DEPTH, then drains in order.
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    check("full_count", fq.count, 4);
    check("full_no_req", fq.im_req, 0);
    cyc(0, 0, 0, 1);
    check("drain0_pc", fq.out_pc, 32'h0);
    check("drain0_no_req", fq.im_req, 0);
    cyc(0, 0, 0, 1);
    check("drain1_pc", fq.out_pc, 32'h4);
    check("drain1_req", fq.im_req, 1);
    check("drain1_addr", fq.im_addr, 32'h10);
    cyc(0, 0, 0, 1);
    check("drain2_pc", fq.out_pc, 32'h8);
    cyc(0, 0, 0, 1);
    check("drain3_pc", fq.out_pc, 32'hC);
    cyc(0, 0, 0, 1);
    check("drain4_pc", fq.out_pc, 32'h10);

    // Redirect with 3 queued entries, colliding with a response carrying 0xDEADBEEF.
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    tick();
    rst              = 1'b0;
    fq.redirect      = 1'b1;
    fq.redirect_addr = 32'h40;
    fq.out_ready     = 1'b1;
    fq.im_rdata      = 32'hDEADBEEF;
    #1;
    check("redir_pre_count", fq.count, 3);
    check("redir_valid", fq.out_valid, 0);
    check("redir_req", fq.im_req, 1);
    check("redir_addr", fq.im_addr, 32'h40);
    cyc(0, 0, 0, 1);
    check("redir1_count", fq.count, 0);
    check("redir1_valid", fq.out_valid, 0);
    cyc(0, 0, 0, 1);
    check("redir2_pc", fq.out_pc, 32'h40);
    check("redir2_inst", fq.out_inst, mem_data(32'h40));
    cyc(0, 0, 0, 1);
    check("redir3_pc", fq.out_pc, 32'h44);

    // Reset mid-operation with count = 3 and a response in flight.
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("midrst_pre_count", fq.count, 3);
    cyc(0, 0, 0, 0);
    check("midrst_count", fq.count, 0);
    check("midrst_valid", fq.out_valid, 0);
    check("midrst_req", fq.im_req, 1);
    check("midrst_addr", fq.im_addr, 32'h0);

    // Address wrap-around.
    cyc(0, 1, 32'hFFFF_FFF8, 1);
    check("wrap0_addr", fq.im_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1);
    check("wrap1_addr", fq.im_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    check("wrap2_addr", fq.im_addr, 32'h0);
    check("wrap2_pc", fq.out_pc, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1);
    check("wrap3_pc", fq.out_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    check("wrap4_pc", fq.out_pc, 32'h0);

    // Irregular stall pattern, checked by the model only.
    pat = 20'b1011_0010_1110_0110_1001;
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, pat[i]);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    check("deadbeef_never_output", seen_dead, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the fetch-to-decode pipeline register. It generates sequential fetch addresses and issues one-cycle-latency reads to the instruction memory. Returned instructions are buffered with their PCs in a small FIFO, so decode stalls no longer throw away fetch bandwidth. A taken branch from the execute stage redirects fetch and discards all queued and in-flight instructions.

## Interface
Parameters:
- DEPTH, 4: FIFO entries, a power of two of at least 2.
- ADDR_W, 32: PC and memory address width.
- DATA_W, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  Single clock. All state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- im_req  out  1  Read request to instruction memory.
- im_addr  out  ADDR_W  Read address, valid when im_req is 1.
- im_rvalid  in  1  Read data valid. It is asserted exactly one cycle after im_req.
- im_rdata  in  DATA_W  Instruction returned by the memory.
- redirect  in  1  Taken branch or flush from the execute stage.
- redirect_addr  in  ADDR_W  New fetch target, valid when redirect is 1.
- out_valid  out  1  The queue head is valid toward the fetch/decode register.
- out_pc  out  ADDR_W  PC of the queue head.
- out_inst  out  DATA_W  Instruction at the queue head.
- out_ready  in  1  The consumer accepts the head; driven as the inverse of the fetch/decode stall.
- count  out  $clog2(DEPTH+1)  Number of occupied entries.

## Operation
State:
- fetch_pc (ADDR_W).
- inflight bit: a request has been issued and its response has not yet returned.
- FIFO storage pc[DEPTH], inst[DEPTH], with wr_ptr and rd_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH.
- count.

Issue rule:
- Normal cycle: im_req = (count + inflight < DEPTH). This rule is conservative and gives no credit for a pop in the same cycle.
- Normal cycle: im_addr = fetch_pc. On issue, fetch_pc <= fetch_pc + 4, with ADDR_W wrap-around.
- Redirect cycle: im_req = 1 and im_addr = redirect_addr. Then fetch_pc <= redirect_addr + 4.
- inflight <= im_req.

Response:
- When im_rvalid = 1 and redirect = 0, write {pc of the matching request, im_rdata} at wr_ptr, then increment wr_ptr.
- The request PC is held in a register captured at issue time.
- When im_rvalid = 1 and redirect = 1, the response belongs to the old path and is dropped.
- im_rvalid with inflight = 0 is ignored.

Output:
- out_valid = (count != 0) && !redirect.
- out_pc and out_inst are the entry at rd_ptr, read combinationally from the storage registers.
- A pop happens when out_valid && out_ready; rd_ptr then increments.

count update:
- +1 on push, -1 on pop, unchanged when both happen in the same cycle.

Redirect:
- Clears wr_ptr, rd_ptr and count to 0 at the edge.
- Suppresses any pop in that cycle.
- The redirect request it issues returns in the next cycle as a normal push.

Boundaries:
- Full: the credit rule guarantees a push never occurs with count = DEPTH. The bench asserts this.
- Empty: out_valid = 0. There is no bypass from im_rdata to the output.
- Both rst and redirect high: rst wins.
- Both redirect and out_ready high: no pop occurs and nothing is consumed.

## Timing
Reset values while rst = 1:
- im_req = 0 and out_valid = 0.
- count = 0, inflight = 0, pointers = 0.
- fetch_pc = RESET_PC.
- out_pc, out_inst and all storage = 0.
- A response arriving during reset is ignored.

Reset deassertion and latency:
- Let t be the first cycle with rst = 0. Then im_req = 1 with im_addr = RESET_PC, im_rvalid arrives at t+1 and is pushed, and out_valid = 1 at t+2.
- Redirect latency is the same: redirect at t, head valid with out_pc = redirect_addr at t+2.

Steady state with out_ready = 1:
- One request per cycle, count holds at 1, one instruction delivered per cycle with consecutive PCs.

Reset mid-operation:
- All state returns to the reset values at the next edge.
- Fetch restarts at RESET_PC in the first cycle after reset.

## Test plan
- Reset then out_ready = 1: im_addr = 0x0, 0x4, 0x8 in cycles t, t+1, t+2; out_valid is first seen at t+2 with out_pc = 0x0, then 0x4 and 0x8 on consecutive cycles; count stays 1.
- out_ready held at 0 from reset: exactly 4 requests are issued (0x0, 0x4, 0x8, 0xC), then im_req = 0 and count = 4. Releasing out_ready drains 0x0 through 0xC in order, and fetch resumes at 0x10.
- Queue holding 3 entries, redirect with redirect_addr = 0x40 for one cycle: out_valid = 0 and im_addr = 0x40 in that cycle; count = 0 next cycle; out_pc = 0x40 two cycles after the redirect, then 0x44. The old-path response is never output.
- Redirect in the same cycle as im_rvalid carrying 0xDEADBEEF: that data never appears on out_inst.
- rst asserted for one cycle while count = 3 and inflight = 1: next cycle count = 0 and out_valid = 0; the first request after reset uses im_addr = RESET_PC.
- fetch_pc = 0xFFFFFFFC with out_ready = 1: the next im_addr = 0x00000000 (wrap), and out_pc shows 0xFFFFFFFC then 0x0.
